store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//   Write buffer between the CPU load/store path and datamemory. Accepts stores
//   in one cycle, queues them FIFO, and drains them into datamemory's write port
//   when the shared address port is free. Loads have priority on the port and
//   are forwarded from the youngest matching buffered store.
// PARAMETERS
//   DEPTH   4    number of buffered stores (power of 2, >=2)
//   ADDR_W  32   word-address width, matches datamemory Addr
//   DATA_W  32   data width, matches datamemory DataIn/DataOut
// PORTS
//   clk          in   1                rising-edge clock
//   reset        in   1                asynchronous, active-high; clears all state
//   st_valid     in   1                CPU store request
//   st_ready     out  1                buffer accepts store this cycle
//   st_addr      in   ADDR_W           store word address
//   st_data      in   DATA_W           store data
//   ld_valid     in   1                CPU load request (owns mem port this cycle)
//   ld_addr      in   ADDR_W           load word address
//   ld_data      out  DATA_W           load result (combinational)
//   mem_regWE    out  1                to datamemory regWE
//   mem_Addr     out  ADDR_W           to datamemory Addr
//   mem_DataIn   out  DATA_W           to datamemory DataIn
//   mem_DataOut  in   DATA_W           from datamemory DataOut
//   count        out  $clog2(DEPTH+1)  entries held
//   empty        out  1                count==0
//   full         out  1                count==DEPTH
// BEHAVIOUR
//   - Reset (async): count=0, head/tail ptrs=0, entries invalid; hence empty=1,
//     full=0, mem_regWE=0. st_ready=0 while reset is high. Pending stores dropped.
//   - st_ready = !full && !reset. Push when st_valid&&st_ready at posedge clk;
//     entry written at tail, tail wraps DEPTH-1 -> 0. No pass-through: a store
//     offered while full is refused even if a drain occurs the same cycle.
//   - Port arbitration (combinational, per cycle):
//       ld_valid=1            : mem_Addr=ld_addr, mem_regWE=0, no drain.
//       ld_valid=0 && !empty  : mem_Addr=head.addr, mem_DataIn=head.data,
//                               mem_regWE=1; head pops at same posedge
//                               (datamemory writes on that edge).
//       ld_valid=0 && empty   : mem_regWE=0, mem_Addr=ld_addr.
//   - Latency: store accepted at edge N is drainable in cycle after N; earliest
//     memory write at edge N+1. Drain rate 1 entry/cycle.
//   - Forwarding: ld_data = data of youngest valid entry with addr==ld_addr
//     (full ADDR_W compare) else mem_DataOut. A store being pushed in the same
//     cycle is NOT visible to a load in that cycle. An entry draining this cycle
//     is impossible (load blocks drain), so no drain/forward race.
//   - Simultaneous push+pop: count unchanged, both pointers advance.
//   - Duplicate addresses allowed; drained in order, so memory ends with youngest.
//   - mem_DataIn = head.data whenever !empty (don't-care when empty, drive 0).
// TESTING
//   1 Reset: assert reset mid-drain with 3 entries -> count=0, empty=1,
//     mem_regWE=0 immediately; memory holds only stores drained before reset.
//   2 Store A=0x10 D=0xDEADBEEF, ld_valid=0 -> mem_regWE=1, mem_Addr=0x10 next
//     cycle; mem[0x10]=0xDEADBEEF after edge; empty=1.
//   3 Fill: 4 stores with ld_valid=1 held -> full=1, st_ready=0, 5th store
//     refused; release ld_valid -> 4 drains in 4 cycles, FIFO order.
//   4 Forward: stores 0x20<=1 then 0x20<=2, ld_valid=1 ld_addr=0x20 ->
//     ld_data=2; ld_addr=0x24 -> ld_data=mem_DataOut.
//   5 Push+drain same cycle with count=2 -> count stays 2, pointers wrap past
//     DEPTH-1 correctly over 10 such cycles; final memory contents match model.
//   6 Random store/load mix vs. golden memory model, 10k cycles -> every
//     ld_data matches model, no store lost or reordered.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between the CPU load/store path and datamemory.
// Stores are queued FIFO and drained one per cycle whenever no load owns the
// shared memory port. Loads see the youngest buffered store to the same word.

// Per-entry address comparator used by load forwarding.
module store_buffer_match #(
    parameter int ADDR_W = 32
) (
    input  logic              vld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              hit
);
    assign hit = vld && (addr == ld_addr);
endmodule

module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       mem_regWE,
    output logic [ADDR_W-1:0]          mem_Addr,
    output logic [DATA_W-1:0]          mem_DataIn,
    input  logic [DATA_W-1:0]          mem_DataOut,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    sb_entry_t [DEPTH-1:0] ent;
    logic      [DEPTH-1:0] vld;
    logic      [DEPTH-1:0] hit;
    logic      [PTR_W-1:0] head, tail;
    logic                  push, pop;
    logic                  fwd_hit;
    logic      [DATA_W-1:0] fwd_data;
    logic      [PTR_W-1:0] idx;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // No pass-through: a full buffer refuses even if it drains this cycle.
    assign st_ready = !full && !reset;
    assign push     = st_valid && st_ready;
    // Loads own the port; the head drains only on cycles without a load.
    assign pop      = !ld_valid && !empty;

    assign mem_regWE  = pop;
    assign mem_Addr   = pop ? ent[head].addr : ld_addr;
    assign mem_DataIn = empty ? '0 : ent[head].data;

    // Queue storage, pointers and occupancy; pointers wrap on power-of-2 depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent   <= '0;
            vld   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                ent[tail].addr <= st_addr;
                ent[tail].data <= st_data;
                vld[tail]      <= 1'b1;
                tail           <= tail + PTR_W'(1);
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            store_buffer_match #(.ADDR_W(ADDR_W)) u_match (
                .vld     (vld[gi]),
                .addr    (ent[gi].addr),
                .ld_addr (ld_addr),
                .hit     (hit[gi])
            );
        end
    endgenerate

    // Walk entries oldest to youngest so the last hit (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (hit[idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = ent[idx].data;
            end
        end
    end

    assign ld_data = fwd_hit ? fwd_data : mem_DataOut;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus queues per-cycle expectations,
// a negedge monitor compares them against the DUT and a small datamemory.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr, st_data;
    logic        ld_valid;
    logic [31:0] ld_addr, ld_data;
    logic        mem_regWE;
    logic [31:0] mem_Addr, mem_DataIn, mem_DataOut;
    logic [2:0]  count;
    logic        empty, full;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .mem_regWE(mem_regWE), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
        .mem_DataOut(mem_DataOut),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Small word-addressed datamemory: synchronous write, combinational read.
    logic [31:0] tmem [64];
    logic        mem_clr;
    assign mem_DataOut = tmem[mem_Addr[5:0]];

    function automatic logic [31:0] def(input int a);
        return 32'hC0DE_0000 | a;
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) tmem[i] <= def(i);
        end else if (mem_regWE) begin
            tmem[mem_Addr[5:0]] <= mem_DataIn;
        end
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
        end
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    typedef struct {
        logic        ldv;
        logic [31:0] la, ld, hd;
        logic        wr;
        logic [31:0] wa, wd;
        int          cnt;
        logic        full, empty, rdy;
    } exp_t;

    exp_t        expq [$];
    st_t         mq   [$];
    logic [31:0] gold [64];

    // Monitor: one queued expectation per stimulus cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("count", {29'd0, count}, e.cnt);
            chk("full", {31'd0, full}, {31'd0, e.full});
            chk("empty", {31'd0, empty}, {31'd0, e.empty});
            chk("st_ready", {31'd0, st_ready}, {31'd0, e.rdy});
            chk("mem_regWE", {31'd0, mem_regWE}, {31'd0, e.wr});
            if (e.wr) begin
                chk("wr_addr", mem_Addr, e.wa);
                chk("wr_data", mem_DataIn, e.wd);
            end else begin
                chk("mem_Addr_ld", mem_Addr, e.la);
            end
            if (e.empty) chk("mem_DataIn_empty", mem_DataIn, 32'd0);
            else         chk("mem_DataIn_head", mem_DataIn, e.hd);
            if (e.ldv) chk("ld_data", ld_data, e.ld);
        end
    end

    // One clock of stimulus; expectations come from the FIFO model and the
    // architectural memory image (youngest accepted store per address).
    task automatic cyc(input logic stv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic ldv, input logic [31:0] la);
        exp_t e;
        st_t  s;
        int   n;
        n       = mq.size();
        e.cnt   = n;
        e.full  = (n == DEPTH);
        e.empty = (n == 0);
        e.rdy   = (n < DEPTH);
        e.ldv   = ldv;
        e.la    = la;
        e.ld    = gold[la[5:0]];
        e.wr    = !ldv && (n > 0);
        e.hd    = (n > 0) ? mq[0].data : 32'd0;
        e.wa    = (n > 0) ? mq[0].addr : 32'd0;
        e.wd    = e.hd;
        expq.push_back(e);
        st_valid = stv; st_addr = sa; st_data = sd;
        ld_valid = ldv; ld_addr = la;
        @(posedge clk);
        if (e.wr) void'(mq.pop_front());
        if (stv && n < DEPTH) begin
            s.addr = sa; s.data = sd;
            mq.push_back(s);
            gold[sa[5:0]] = sd;
        end
        #1;
    endtask

    task automatic mem_compare(input string nm);
        for (int i = 0; i < 64; i++) chk(nm, tmem[i], gold[i]);
    endtask

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0;
        for (int i = 0; i < 64; i++) gold[i] = def(i);
        #1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_st_ready", {31'd0, st_ready}, 32'd0);
        chk("rst_regWE", {31'd0, mem_regWE}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; mem_clr = 1'b0;

        // Reset mid-drain: three held behind a load, one drained, then reset.
        cyc(1, 32'h01, 32'h1111_1111, 1, 32'h3F);
        cyc(1, 32'h02, 32'h2222_2222, 1, 32'h3F);
        cyc(1, 32'h03, 32'h3333_3333, 1, 32'h3F);
        cyc(0, 32'h00, 32'h0, 0, 32'h00);
        st_valid = 1'b0; ld_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_regWE", {31'd0, mem_regWE}, 32'd0);
        chk("mid_rst_st_ready", {31'd0, st_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mem1", tmem[1], 32'h1111_1111);
        chk("rst_mem2", tmem[2], def(2));
        chk("rst_mem3", tmem[3], def(3));
        mq.delete();
        for (int i = 0; i < 64; i++) gold[i] = def(i);
        gold[1] = 32'h1111_1111;

        // Single store drains on the following cycle.
        cyc(1, 32'h10, 32'hDEAD_BEEF, 0, 32'h00);
        cyc(0, 32'h00, 32'h0, 0, 32'h00);
        cyc(0, 32'h00, 32'h0, 0, 32'h05);
        chk("mem_10", tmem[16], 32'hDEAD_BEEF);

        // Fill behind a held load, fifth store refused, then four in-order drains.
        for (int i = 0; i < 5; i++)
            cyc(1, 32'h30 + i, 32'hA000_0000 + i, 1, 32'h30);
        cyc(0, 32'h0, 32'h0, 1, 32'h34);
        for (int i = 0; i < 5; i++) cyc(0, 32'h0, 32'h0, 0, 32'h00);

        // Forwarding: same-cycle store invisible, youngest match wins, miss reads memory.
        cyc(1, 32'h20, 32'd1, 1, 32'h20);
        cyc(1, 32'h20, 32'd2, 1, 32'h20);
        cyc(0, 32'h00, 32'd0, 1, 32'h20);
        cyc(0, 32'h00, 32'd0, 1, 32'h24);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 32'h0, 0, 32'h00);
        chk("mem_20", tmem[32], 32'd2);

        // Push and drain together at count 2 so both pointers wrap repeatedly.
        cyc(1, 32'h08, 32'hB000_0000, 1, 32'h00);
        cyc(1, 32'h09, 32'hB000_0001, 1, 32'h00);
        for (int i = 0; i < 10; i++)
            cyc(1, 32'h08 + (i % 5), 32'hB100_0000 + i, 0, 32'h00);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 32'h0, 0, 32'h00);
        mem_compare("mem_wrap");

        // Random store/load mix on a small address set to force duplicates.
        for (int i = 0; i < 10000; i++)
            cyc(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
                1'($urandom_range(0, 2) == 0), 32'($urandom_range(0, 15)));
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 32'h0, 32'h0, 0, 32'h00);
        mem_compare("mem_rand");

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
